// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage.
// Optional forwarding/snoop logic is enabled by defining ALU_ISSUE_FWD_EN.
package alu_pkg;

    localparam int ALUFN_W    = 6;
    localparam int LIT_W      = 16;
    localparam int REG_AW_DEF = 5;

    // Hard-wired zero register at the default address width.
    localparam logic [REG_AW_DEF-1:0] R31 = 5'd31;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_entry.sv
// One issue-buffer slot: captures an op with operand selection and, when
// ALU_ISSUE_FWD_EN is defined, snoops writebacks for its pending source registers.
module alu_issue_entry
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               kill,
    input  logic [ALUFN_W-1:0] in_alufn,
    input  logic [REG_AW-1:0]  in_ra,
    input  logic [REG_AW-1:0]  in_rb,
    input  logic [REG_AW-1:0]  in_rc,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic               in_use_lit,
    input  logic [LIT_W-1:0]   in_lit,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_rc,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [ALUFN_W-1:0] alufn,
    output logic [DATA_W-1:0]  a,
    output logic [DATA_W-1:0]  b,
    output logic [REG_AW-1:0]  rc
);

    // Top address of the register file is the zero register at any width.
    localparam logic [REG_AW-1:0] ZERO_REG = '1;

    logic              ra_zero;
    logic              rb_zero;
    logic [DATA_W-1:0] lit_ext;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic              hit_a;
    logic              hit_b;

    assign ra_zero = (in_ra == ZERO_REG);
    assign rb_zero = (in_rb == ZERO_REG);
    assign lit_ext = {{(DATA_W-LIT_W){in_lit[LIT_W-1]}}, in_lit};

`ifdef ALU_ISSUE_FWD_EN
    logic              fwd_a;
    logic              fwd_b;
    logic              pend_a;
    logic              pend_b;
    logic [REG_AW-1:0] tag_a;
    logic [REG_AW-1:0] tag_b;

    assign fwd_a = wb_valid && (wb_rc == in_ra) && !ra_zero;
    assign fwd_b = wb_valid && (wb_rc == in_rb) && !rb_zero;

    assign cap_a = ra_zero    ? '0 :
                   fwd_a      ? wb_data : in_a;
    assign cap_b = in_use_lit ? lit_ext :
                   rb_zero    ? '0 :
                   fwd_b      ? wb_data : in_b;

    // Tags are only armed for non-zero registers, so wb_rc==R31 can never hit.
    assign hit_a = pend_a && wb_valid && (wb_rc == tag_a);
    assign hit_b = pend_b && wb_valid && (wb_rc == tag_b);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else if (load) begin
            pend_a <= !ra_zero;
            pend_b <= !in_use_lit && !rb_zero;
        end else if (kill) begin
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            tag_a <= in_ra;
            tag_b <= in_rb;
        end
    end
`else
    logic unused_ok;

    assign cap_a = ra_zero    ? '0 : in_a;
    assign cap_b = in_use_lit ? lit_ext :
                   rb_zero    ? '0 : in_b;
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
    assign unused_ok = &{1'b0, kill, wb_valid, wb_rc};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alufn <= '0;
            rc    <= '0;
            a     <= '0;
            b     <= '0;
        end else if (load) begin
            alufn <= in_alufn;
            rc    <= in_rc;
            a     <= cap_a;
            b     <= cap_b;
        end else begin
            if (hit_a) a <= wb_data;
            if (hit_b) b <= wb_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-deep in-order issue skid buffer between decode and the ALU.
// Writeback forwarding/snoop is compiled in when ALU_ISSUE_FWD_EN is defined.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUFN_W-1:0] in_alufn,
    input  logic [REG_AW-1:0]  in_ra,
    input  logic [REG_AW-1:0]  in_rb,
    input  logic [REG_AW-1:0]  in_rc,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic               in_use_lit,
    input  logic [LIT_W-1:0]   in_lit,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_rc,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUFN_W-1:0] out_alufn,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b,
    output logic [REG_AW-1:0]  out_rc
);

    issue_state_t state;
    issue_state_t state_nxt;
    logic         head;
    logic         tail;
    logic         accept;
    logic         pop;
    logic [1:0]   load;
    logic [1:0]   kill;

    logic [ALUFN_W-1:0] e_alufn [2];
    logic [DATA_W-1:0]  e_a     [2];
    logic [DATA_W-1:0]  e_b     [2];
    logic [REG_AW-1:0]  e_rc    [2];

    // Handshake flags decode straight from the state register, never from out_ready.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);

    assign accept = in_valid && in_ready && !flush;
    assign pop    = out_valid && out_ready;

    // Slots ping-pong: a new op lands in the head slot when empty, else the other one.
    assign tail = (state == EMPTY) ? head : ~head;

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !pop)      state_nxt = FULL;
                else if (!accept && pop) state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= EMPTY;
            head  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop && !flush) head <= ~head;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_entry
        assign load[i] = accept && (tail == 1'(i));
        assign kill[i] = flush || (pop && (head == 1'(i)) && !load[i]);

        alu_issue_entry #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_entry (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (load[i]),
            .kill       (kill[i]),
            .in_alufn   (in_alufn),
            .in_ra      (in_ra),
            .in_rb      (in_rb),
            .in_rc      (in_rc),
            .in_a       (in_a),
            .in_b       (in_b),
            .in_use_lit (in_use_lit),
            .in_lit     (in_lit),
            .wb_valid   (wb_valid),
            .wb_rc      (wb_rc),
            .wb_data    (wb_data),
            .alufn      (e_alufn[i]),
            .a          (e_a[i]),
            .b          (e_b[i]),
            .rc         (e_rc[i])
        );
    end

    assign out_alufn = e_alufn[head];
    assign out_a     = e_a[head];
    assign out_b     = e_b[head];
    assign out_rc    = e_rc[head];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage; expectations follow ALU_ISSUE_FWD_EN.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_alufn;
    logic [REG_AW-1:0] in_ra;
    logic [REG_AW-1:0] in_rb;
    logic [REG_AW-1:0] in_rc;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_use_lit;
    logic [15:0]       in_lit;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rc;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_alufn;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [REG_AW-1:0] out_rc;

    typedef struct packed {
        logic [5:0]        alufn;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] rc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_issue_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alufn   (in_alufn),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .in_rc      (in_rc),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_lit (in_use_lit),
        .in_lit     (in_lit),
        .wb_valid   (wb_valid),
        .wb_rc      (wb_rc),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alufn  (out_alufn),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rc     (out_rc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid&&ready is seen here.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got a=%0h b=%0h, expected no output", out_a, out_b);
            end else begin
                mon_e = sb.pop_front();
                check("out_alufn", 64'(out_alufn), 64'(mon_e.alufn));
                check("out_a",     64'(out_a),     64'(mon_e.a));
                check("out_b",     64'(out_b),     64'(mon_e.b));
                check("out_rc",    64'(out_rc),    64'(mon_e.rc));
            end
        end
    end

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_alufn   = '0;
        in_ra      = '0;
        in_rb      = '0;
        in_rc      = '0;
        in_a       = '0;
        in_b       = '0;
        in_use_lit = 1'b0;
        in_lit     = '0;
        wb_valid   = 1'b0;
        wb_rc      = '0;
        wb_data    = '0;
        flush      = 1'b0;
    endtask

    task automatic drive_op(input logic [5:0] fn, input logic [4:0] ra, input logic [4:0] rb,
                            input logic [4:0] rc, input logic [31:0] a, input logic [31:0] b,
                            input logic ul, input logic [15:0] lit);
        in_valid   = 1'b1;
        in_alufn   = fn;
        in_ra      = ra;
        in_rb      = rb;
        in_rc      = rc;
        in_a       = a;
        in_b       = b;
        in_use_lit = ul;
        in_lit     = lit;
    endtask

    task automatic push_op(input logic [5:0] fn, input logic [4:0] ra, input logic [4:0] rb,
                           input logic [4:0] rc, input logic [31:0] a, input logic [31:0] b,
                           input logic ul, input logic [15:0] lit,
                           input logic [31:0] ea, input logic [31:0] eb);
        logic acc = 1'b0;
        logic rdy;
        drive_op(fn, ra, rb, rc, a, b, ul, lit);
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = 1'b1;
        end
        in_valid = 1'b0;
        if (acc) sb.push_back({fn, ea, eb, rc});
        else begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_a",     64'(out_a),     64'd0);
        check("rst_out_b",     64'(out_b),     64'd0);
        check("rst_out_rc",    64'(out_rc),    64'd0);
        check("rst_out_alufn", 64'(out_alufn), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic op with one-cycle latency.
        out_ready = 1'b1;
        drive_op(6'h00, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 1'b0, 16'h0);
        @(negedge clk);
        check("same_cycle_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back({6'h00, 32'd5, 32'd7, 5'd4});
        check("latency_valid", 64'(out_valid), 64'd1);
        drain();

        // Literal, R31 zero, back-to-back streaming.
        push_op(6'h1A, 5'd31, 5'd2, 5'd3, 32'd9, 32'h55, 1'b1, 16'hFFFE, 32'd0, 32'hFFFF_FFFE);
        push_op(6'h02, 5'd4, 5'd31, 5'd8, 32'h1234, 32'h77, 1'b0, 16'h0, 32'h1234, 32'd0);
        push_op(6'h05, 5'd5, 5'd6, 5'd7, 32'h10, 32'h20, 1'b1, 16'h7FFF, 32'h10, 32'h0000_7FFF);
        drain();

        // Stall: fill, refuse a third op, hold head stable, then drain in order.
        out_ready = 1'b0;
        push_op(6'h03, 5'd1, 5'd2, 5'd5, 32'hAAAA, 32'hBBBB, 1'b0, 16'h0, 32'hAAAA, 32'hBBBB);
        push_op(6'h04, 5'd6, 5'd7, 5'd9, 32'hCCCC, 32'hDDDD, 1'b0, 16'h0, 32'hCCCC, 32'hDDDD);
        drive_op(6'h3F, 5'd8, 5'd9, 5'd10, 32'hEEEE, 32'hFFFF, 1'b0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_in_ready", 64'(in_ready), 64'd0);
            check("stall_hold_a",  64'(out_a),    64'hAAAA);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Stalled head snoops writeback; R31 writeback ignored.
        out_ready = 1'b0;
        push_op(6'h06, 5'd3, 5'd4, 5'd10, 32'h11, 32'h22, 1'b0, 16'h0,
                FWD ? 32'hDEAD : 32'h11, 32'h22);
        wb_valid = 1'b1;
        wb_rc    = 5'd3;
        wb_data  = 32'hDEAD;
        @(posedge clk);
        #1;
        wb_rc    = 5'd31;
        wb_data  = 32'hBEEF;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        @(negedge clk);
        check("snoop_a", 64'(out_a), FWD ? 64'hDEAD : 64'h11);
        check("snoop_b", 64'(out_b), 64'h22);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Accept + pop + matching writeback in the same cycle.
        out_ready = 1'b0;
        push_op(6'h07, 5'd6, 5'd1, 5'd11, 32'h61, 32'h62, 1'b0, 16'h0, 32'h61, 32'h62);
        out_ready = 1'b1;
        wb_valid  = 1'b1;
        wb_rc     = 5'd6;
        wb_data   = 32'hCAFE;
        push_op(6'h08, 5'd6, 5'd6, 5'd12, 32'h71, 32'h72, 1'b0, 16'h0,
                FWD ? 32'hCAFE : 32'h71, FWD ? 32'hCAFE : 32'h72);
        wb_valid  = 1'b0;
        drain();

        // Both held entries snoop the same writeback.
        out_ready = 1'b0;
        push_op(6'h09, 5'd7, 5'd1, 5'd13, 32'h1, 32'h5, 1'b0, 16'h0,
                FWD ? 32'hBEE0 : 32'h1, 32'h5);
        push_op(6'h0A, 5'd2, 5'd7, 5'd14, 32'h3, 32'h2, 1'b0, 16'h0,
                32'h3, FWD ? 32'hBEE0 : 32'h2);
        wb_valid = 1'b1;
        wb_rc    = 5'd7;
        wb_data  = 32'hBEE0;
        @(posedge clk);
        #1;
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Flush while full with a competing accept.
        out_ready = 1'b0;
        push_op(6'h0B, 5'd1, 5'd2, 5'd15, 32'hA1, 32'hA2, 1'b0, 16'h0, 32'hA1, 32'hA2);
        push_op(6'h0C, 5'd1, 5'd2, 5'd16, 32'hB1, 32'hB2, 1'b0, 16'h0, 32'hB1, 32'hB2);
        drive_op(6'h0D, 5'd1, 5'd2, 5'd17, 32'h5A5A, 32'h5B5B, 1'b0, 16'h0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        push_op(6'h0E, 5'd1, 5'd2, 5'd18, 32'h77, 32'h78, 1'b0, 16'h0, 32'h77, 32'h78);
        drain();

        // Reset while full and stalled, with an accept pending.
        out_ready = 1'b0;
        push_op(6'h0F, 5'd1, 5'd2, 5'd19, 32'hC1, 32'hC2, 1'b0, 16'h0, 32'hC1, 32'hC2);
        push_op(6'h10, 5'd1, 5'd2, 5'd20, 32'hD1, 32'hD2, 1'b0, 16'h0, 32'hD1, 32'hD2);
        drive_op(6'h11, 5'd1, 5'd2, 5'd21, 32'hE1, 32'hE2, 1'b0, 16'h0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.delete();
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_in_ready",  64'(in_ready),  64'd1);
        check("rst2_out_a",     64'(out_a),     64'd0);
        check("rst2_out_b",     64'(out_b),     64'd0);
        check("rst2_out_rc",    64'(out_rc),    64'd0);
        check("rst2_out_alufn", 64'(out_alufn), 64'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push_op(6'h12, 5'd9, 5'd31, 5'd22, 32'h99, 32'h98, 1'b0, 16'h0, 32'h99, 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
